// File: rtl/icache_mshr_ctrl.sv
// icache_mshr_ctrl
//   Non-blocking instruction-cache miss controller. Tracks up to MSHR_DEPTH
//   outstanding block misses for FETCH_WIDTH fetch lanes. It issues one memory
//   load per cycle, retries requests the bus rejects, matches out-of-order
//   return tags, and forwards returning fill data straight to fetch.
//
// Ports
//   clock, reset             clock; asynchronous active-high reset
//   flush                    fetch redirect; drops misses not yet issued
//   proc2Icache_addr         per-lane fetch PC
//   cachemem_data/valid      per-lane array read block / hit
//   Imem2proc_response       tag accepted for this cycle's load (0 = rejected)
//   Imem2proc_data/tag       returning block and its tag (0 = none)
//   current_index/tag        per-lane array lookup fields
//   proc2Imem_command/addr   memory load request
//   wr_en/index/tag/data     array fill port
//   Icache_data_out/valid    per-lane instruction word and valid
//   mshr_full                no free miss entry
module icache_mshr_ctrl #(
  parameter int XLEN         = 32,
  parameter int FETCH_WIDTH  = 3,
  parameter int IDX_BITS     = 5,
  parameter int MSHR_DEPTH   = 4,
  parameter int MEM_TAG_BITS = 4,
  localparam int TAG_BITS    = XLEN - 3 - IDX_BITS
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0]       proc2Icache_addr,
  input  logic [FETCH_WIDTH-1:0][63:0]           cachemem_data,
  input  logic [FETCH_WIDTH-1:0]                 cachemem_valid,
  input  logic [MEM_TAG_BITS-1:0]                Imem2proc_response,
  input  logic [63:0]                            Imem2proc_data,
  input  logic [MEM_TAG_BITS-1:0]                Imem2proc_tag,
  output logic [FETCH_WIDTH-1:0][IDX_BITS-1:0]   current_index,
  output logic [FETCH_WIDTH-1:0][TAG_BITS-1:0]   current_tag,
  output logic [1:0]                             proc2Imem_command,
  output logic [XLEN-1:0]                        proc2Imem_addr,
  output logic                                   wr_en,
  output logic [IDX_BITS-1:0]                    wr_index,
  output logic [TAG_BITS-1:0]                    wr_tag,
  output logic [63:0]                            wr_data,
  output logic [FETCH_WIDTH-1:0][31:0]           Icache_data_out,
  output logic [FETCH_WIDTH-1:0]                 Icache_valid_out,
  output logic                                   mshr_full
);

  localparam int BLK_BITS = XLEN - 3;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic [1:0] {M_FREE = 2'd0, M_PEND = 2'd1, M_WAIT = 2'd2} mstate_e;

  typedef struct packed {
    mstate_e                 st;
    logic [TAG_BITS-1:0]     tag;
    logic [IDX_BITS-1:0]     idx;
    logic [MEM_TAG_BITS-1:0] mtag;
  } mshr_t;

  mshr_t [MSHR_DEPTH-1:0] ent_q, ent_d;

  logic [MSHR_DEPTH-1:0][BLK_BITS-1:0]  ent_blk;
  logic [FETCH_WIDTH-1:0][BLK_BITS-1:0] lane_blk;
  logic [MSHR_DEPTH-1:0]  free_v, pend_v, fill_v, free_oh, iss_oh, fill_oh;
  logic [FETCH_WIDTH-1:0] byp, tracked, miss_v, miss_oh, vld;
  logic [BLK_BITS-1:0]    fill_blk, iss_blk, alloc_blk;
  logic                   fill_go, iss_go, alloc_go;

  logic [FETCH_WIDTH-1:0][1:0] addr_lsbs;
  logic                        unused_addr_lsbs;

  // Decode: entry classes, lowest-index pickers (v & -v), lane hit/miss.
  always_comb begin : decode
    ent_blk  = '0;
    free_v   = '0;
    pend_v   = '0;
    fill_v   = '0;
    fill_blk = '0;
    iss_blk  = '0;
    for (int k = 0; k < MSHR_DEPTH; k++) begin
      ent_blk[k] = {ent_q[k].tag, ent_q[k].idx};
      free_v[k]  = (ent_q[k].st == M_FREE);
      pend_v[k]  = (ent_q[k].st == M_PEND);
      fill_v[k]  = (ent_q[k].st == M_WAIT) && (Imem2proc_tag != '0) &&
                   (ent_q[k].mtag == Imem2proc_tag);
    end
    free_oh = free_v & (~free_v + MSHR_DEPTH'(1));
    iss_oh  = pend_v & (~pend_v + MSHR_DEPTH'(1));
    fill_oh = fill_v & (~fill_v + MSHR_DEPTH'(1));
    fill_go = |fill_v;
    iss_go  = (|pend_v) && !flush;
    for (int k = 0; k < MSHR_DEPTH; k++) begin
      fill_blk = fill_blk | (fill_oh[k] ? ent_blk[k] : '0);
      iss_blk  = iss_blk  | (iss_oh[k]  ? ent_blk[k] : '0);
    end

    lane_blk  = '0;
    byp       = '0;
    tracked   = '0;
    vld       = '0;
    miss_v    = '0;
    alloc_blk = '0;
    addr_lsbs = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_blk[i]  = proc2Icache_addr[i][XLEN-1:3];
      addr_lsbs[i] = proc2Icache_addr[i][1:0];
      byp[i]       = fill_go && (lane_blk[i] == fill_blk);
      vld[i]       = byp[i] | cachemem_valid[i];
      // A block already held by any live entry is never requested twice.
      for (int k = 0; k < MSHR_DEPTH; k++)
        if (!free_v[k] && ent_blk[k] == lane_blk[i]) tracked[i] = 1'b1;
      miss_v[i] = !vld[i] && !tracked[i];
    end
    // Lanes sharing a block with an older candidate lose to it, since only
    // the oldest missing lane allocates in a cycle.
    miss_oh = miss_v & (~miss_v + FETCH_WIDTH'(1));
    for (int i = 0; i < FETCH_WIDTH; i++)
      alloc_blk = alloc_blk | (miss_oh[i] ? lane_blk[i] : '0);
    // free_v is the registered view, so an entry freed by this cycle's fill
    // is not reusable until next cycle.
    alloc_go = (|miss_v) && (|free_v) && !flush;
  end

  assign unused_addr_lsbs = ^addr_lsbs;

  always_ff @(posedge clock or posedge reset) begin : state_reg
    if (reset) begin
      for (int k = 0; k < MSHR_DEPTH; k++) begin
        ent_q[k].st   <= M_FREE;
        ent_q[k].tag  <= '0;
        ent_q[k].idx  <= '0;
        ent_q[k].mtag <= '0;
      end
    end else begin
      ent_q <= ent_d;
    end
  end

  // Flush, issue, fill and allocation each touch a different entry class
  // (PEND / PEND / WAIT / FREE), so their per-entry updates never collide.
  always_comb begin : next_state
    ent_d = ent_q;
    for (int k = 0; k < MSHR_DEPTH; k++) begin
      if (flush && pend_v[k]) ent_d[k].st = M_FREE;
      if (iss_go && iss_oh[k] && (Imem2proc_response != '0)) begin
        ent_d[k].st   = M_WAIT;
        ent_d[k].mtag = Imem2proc_response;
      end
      if (fill_oh[k]) ent_d[k].st = M_FREE;
      if (alloc_go && free_oh[k]) begin
        ent_d[k].st   = M_PEND;
        ent_d[k].tag  = alloc_blk[BLK_BITS-1:IDX_BITS];
        ent_d[k].idx  = alloc_blk[IDX_BITS-1:0];
        ent_d[k].mtag = '0;
      end
    end
  end

  always_comb begin : outputs
    logic [63:0] src;
    src               = '0;
    proc2Imem_command = iss_go ? BUS_LOAD : BUS_NONE;
    proc2Imem_addr    = iss_go ? {iss_blk, 3'b000} : '0;
    wr_en             = fill_go;
    wr_index          = fill_blk[IDX_BITS-1:0];
    wr_tag            = fill_blk[BLK_BITS-1:IDX_BITS];
    wr_data           = Imem2proc_data;
    mshr_full         = ~|free_v;
    Icache_valid_out  = vld;
    Icache_data_out   = '0;
    current_index     = '0;
    current_tag       = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      src                = byp[i] ? Imem2proc_data : cachemem_data[i];
      Icache_data_out[i] = proc2Icache_addr[i][2] ? src[63:32] : src[31:0];
      current_index[i]   = proc2Icache_addr[i][IDX_BITS+2:3];
      current_tag[i]     = proc2Icache_addr[i][XLEN-1:IDX_BITS+3];
    end
  end

endmodule

// File: tb/tb_icache_mshr_ctrl.sv
module tb_icache_mshr_ctrl;

  logic              clock, reset, flush;
  logic [2:0][31:0]  addr;
  logic [2:0][63:0]  cmdat;
  logic [2:0]        cmv;
  logic [3:0]        resp, mtag;
  logic [63:0]       mdata;
  logic [2:0][4:0]   cur_idx;
  logic [2:0][23:0]  cur_tag;
  logic [1:0]        cmd_o;
  logic [31:0]       maddr;
  logic              wr_en;
  logic [4:0]        wr_index;
  logic [23:0]       wr_tag;
  logic [63:0]       wr_data;
  logic [2:0][31:0]  dout;
  logic [2:0]        vout;
  logic              full;

  int ntests = 0;
  int nfail  = 0;

  icache_mshr_ctrl dut (
    .clock(clock), .reset(reset), .flush(flush),
    .proc2Icache_addr(addr), .cachemem_data(cmdat), .cachemem_valid(cmv),
    .Imem2proc_response(resp), .Imem2proc_data(mdata), .Imem2proc_tag(mtag),
    .current_index(cur_idx), .current_tag(cur_tag),
    .proc2Imem_command(cmd_o), .proc2Imem_addr(maddr),
    .wr_en(wr_en), .wr_index(wr_index), .wr_tag(wr_tag), .wr_data(wr_data),
    .Icache_data_out(dout), .Icache_valid_out(vout), .mshr_full(full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; resp = '0; mtag = '0; cmv = 3'b111;
    addr[0] = 32'h900; addr[1] = 32'h900; addr[2] = 32'h904;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One cycle of hand stimulus: lane0 address varies, lanes 1/2 hit.
  task automatic drv(input logic [31:0] a0, input logic [2:0] v, input logic [3:0] rs,
                     input logic [3:0] m, input logic f);
    @(negedge clock);
    addr[0] = a0; addr[1] = 32'h900; addr[2] = 32'h904;
    cmv = v; resp = rs; mtag = m; flush = f;
    #1;
  endtask

  typedef struct packed {
    logic [31:0] a0, a1, a2;
    logic [2:0]  cmv;
    logic [3:0]  rsp, mt;
    logic        fl;
    logic [1:0]  cmd;
    logic [31:0] maddr;
    logic        wr;
    logic [4:0]  widx;
    logic [23:0] wtag;
    logic [2:0]  vld;
    logic        full;
    logic [31:0] d0;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a0, a1, a2, input logic [2:0] c,
                              input logic [3:0] rs, m, input logic f, input logic [1:0] cm,
                              input logic [31:0] ma, input logic w, input logic [4:0] wi,
                              input logic [23:0] wt, input logic [2:0] vl, input logic fu,
                              input logic [31:0] d);
    vec_t r;
    r.a0 = a0; r.a1 = a1; r.a2 = a2; r.cmv = c; r.rsp = rs; r.mt = m; r.fl = f;
    r.cmd = cm; r.maddr = ma; r.wr = w; r.widx = wi; r.wtag = wt; r.vld = vl;
    r.full = fu; r.d0 = d;
    return r;
  endfunction

  // Behavioural reference: each entry is just {busy, sent, block number, mem tag}.
  bit          m_busy [4];
  bit          m_sent [4];
  logic [28:0] m_blk  [4];
  logic [3:0]  m_mt   [4];
  int          fk, ik, al, fr;
  bit          e_full, dup;
  logic [2:0]  e_vld;
  logic [63:0] src;
  vec_t        tv [16];

  initial begin
    do_reset();
    reset = 1'b1;
    #1;
    chk("reset cmd",  64'(cmd_o), 64'(0));
    chk("reset addr", 64'(maddr), 64'(0));
    chk("reset full", 64'(full),  64'(0));
    chk("reset wr_en",64'(wr_en), 64'(0));
    reset = 1'b0;

    // ---- table: single miss, then dedupe of 0x200/0x204/0x208 ----
    cmdat[0] = 64'h1111_2222_3333_4444;
    cmdat[1] = 64'h5555_6666_7777_8888;
    cmdat[2] = 64'h9999_AAAA_BBBB_CCCC;
    mdata    = 64'hDEADBEEF_12345678;
    tv[0]  = mk(32'h100, 32'h900, 32'h904, 3'b110, 0, 0, 0, 0, 0,      0, 0, 0, 3'b110, 0, 32'h33334444);
    tv[1]  = mk(32'h100, 32'h900, 32'h904, 3'b110, 3, 0, 0, 1, 32'h100,0, 0, 0, 3'b110, 0, 32'h33334444);
    tv[2]  = mk(32'h100, 32'h900, 32'h904, 3'b110, 0, 0, 0, 0, 0,      0, 0, 0, 3'b110, 0, 32'h33334444);
    tv[3]  = tv[2];
    tv[4]  = tv[2];
    tv[5]  = mk(32'h100, 32'h900, 32'h904, 3'b110, 0, 3, 0, 0, 0,      1, 0, 1, 3'b111, 0, 32'h12345678);
    tv[6]  = mk(32'h100, 32'h900, 32'h904, 3'b111, 0, 0, 0, 0, 0,      0, 0, 0, 3'b111, 0, 32'h33334444);
    tv[7]  = mk(32'h200, 32'h204, 32'h208, 3'b000, 0, 0, 0, 0, 0,      0, 0, 0, 3'b000, 0, 32'h33334444);
    tv[8]  = mk(32'h200, 32'h204, 32'h208, 3'b000, 0, 0, 0, 1, 32'h200,0, 0, 0, 3'b000, 0, 32'h33334444);
    tv[9]  = tv[8];
    tv[10] = mk(32'h200, 32'h204, 32'h208, 3'b000, 1, 0, 0, 1, 32'h200,0, 0, 0, 3'b000, 0, 32'h33334444);
    tv[11] = mk(32'h200, 32'h204, 32'h208, 3'b000, 2, 0, 0, 1, 32'h208,0, 0, 0, 3'b000, 0, 32'h33334444);
    tv[12] = mk(32'h200, 32'h204, 32'h208, 3'b000, 0, 0, 0, 0, 0,      0, 0, 0, 3'b000, 0, 32'h33334444);
    tv[13] = mk(32'h200, 32'h204, 32'h208, 3'b111, 0, 1, 0, 0, 0,      1, 0, 2, 3'b111, 0, 32'h12345678);
    tv[14] = mk(32'h200, 32'h204, 32'h208, 3'b111, 0, 2, 0, 0, 0,      1, 1, 2, 3'b111, 0, 32'h33334444);
    tv[15] = mk(32'h200, 32'h204, 32'h208, 3'b111, 0, 0, 0, 0, 0,      0, 0, 0, 3'b111, 0, 32'h33334444);
    for (int r = 0; r < 16; r++) begin
      @(negedge clock);
      addr[0] = tv[r].a0; addr[1] = tv[r].a1; addr[2] = tv[r].a2;
      cmv = tv[r].cmv; resp = tv[r].rsp; mtag = tv[r].mt; flush = tv[r].fl;
      #1;
      chk($sformatf("t%0d cmd", r),   64'(cmd_o), 64'(tv[r].cmd));
      chk($sformatf("t%0d maddr", r), 64'(maddr), 64'(tv[r].maddr));
      chk($sformatf("t%0d wr_en", r), 64'(wr_en), 64'(tv[r].wr));
      chk($sformatf("t%0d valid", r), 64'(vout),  64'(tv[r].vld));
      chk($sformatf("t%0d full", r),  64'(full),  64'(tv[r].full));
      chk($sformatf("t%0d data0", r), 64'(dout[0]), 64'(tv[r].d0));
      if (tv[r].wr) begin
        chk($sformatf("t%0d wr_index", r), 64'(wr_index), 64'(tv[r].widx));
        chk($sformatf("t%0d wr_tag", r),   64'(wr_tag),   64'(tv[r].wtag));
      end
    end

    // ---- reject / retry ----
    do_reset();
    drv(32'h300, 3'b110, 0, 0, 0); chk("rr idle", 64'(cmd_o), 64'(0));
    drv(32'h300, 3'b110, 0, 0, 0); chk("rr try1", 64'(maddr), 64'h300);
    drv(32'h300, 3'b110, 0, 0, 0); chk("rr try2", 64'(maddr), 64'h300);
    drv(32'h300, 3'b110, 0, 0, 0); chk("rr try3", 64'(maddr), 64'h300);
    drv(32'h300, 3'b110, 5, 0, 0); chk("rr try4 cmd", 64'(cmd_o), 64'(1));
    drv(32'h900, 3'b111, 0, 0, 0); chk("rr done", 64'(cmd_o), 64'(0));
    drv(32'h900, 3'b111, 0, 5, 0); chk("rr fill wr_en", 64'(wr_en), 64'(1));
    chk("rr fill tag", 64'(wr_tag), 64'(3));

    // ---- full + out-of-order return ----
    do_reset();
    drv(32'h1000, 3'b110, 0, 0, 0); chk("ooo full0", 64'(full), 64'(0));
    drv(32'h2000, 3'b110, 1, 0, 0); chk("ooo iss1", 64'(maddr), 64'h1000);
    drv(32'h3000, 3'b110, 2, 0, 0); chk("ooo iss2", 64'(maddr), 64'h2000);
    drv(32'h4000, 3'b110, 3, 0, 0); chk("ooo iss3", 64'(maddr), 64'h3000);
    drv(32'h5000, 3'b110, 4, 0, 0); chk("ooo iss4", 64'(maddr), 64'h4000);
    chk("ooo full", 64'(full), 64'(1));
    drv(32'h5000, 3'b110, 7, 0, 0); chk("ooo no 5th issue", 64'(cmd_o), 64'(0));
    chk("ooo still full", 64'(full), 64'(1));
    drv(32'h5000, 3'b110, 0, 3, 0); chk("ooo fill3 wr_en", 64'(wr_en), 64'(1));
    chk("ooo fill3 tag", 64'(wr_tag), 64'h30);
    chk("ooo full during fill", 64'(full), 64'(1));
    drv(32'h5000, 3'b110, 0, 0, 0); chk("ooo freed", 64'(full), 64'(0));
    chk("ooo alloc cycle cmd", 64'(cmd_o), 64'(0));
    drv(32'h5000, 3'b110, 6, 0, 0); chk("ooo 5th issue", 64'(maddr), 64'h5000);
    chk("ooo full again", 64'(full), 64'(1));
    drv(32'h900, 3'b111, 0, 6, 0); chk("ooo 5th fill tag", 64'(wr_tag), 64'h50);

    // ---- flush with two PENDING and one WAIT ----
    do_reset();
    drv(32'h600, 3'b110, 0, 0, 0);
    drv(32'h700, 3'b110, 9, 0, 0); chk("fl iss 600", 64'(maddr), 64'h600);
    drv(32'h800, 3'b110, 0, 0, 0); chk("fl iss 700", 64'(maddr), 64'h700);
    drv(32'h900, 3'b111, 0, 0, 1); chk("fl cmd during flush", 64'(cmd_o), 64'(0));
    drv(32'h900, 3'b111, 0, 0, 0); chk("fl pending gone", 64'(cmd_o), 64'(0));
    chk("fl full", 64'(full), 64'(0));
    drv(32'h900, 3'b111, 0, 9, 0); chk("fl wait fill wr_en", 64'(wr_en), 64'(1));
    chk("fl wait fill tag", 64'(wr_tag), 64'h6);

    // ---- asynchronous reset mid-cycle ----
    do_reset();
    drv(32'hA00, 3'b110, 0, 0, 0);
    drv(32'hB00, 3'b110, 2, 0, 0); chk("ar iss A00", 64'(maddr), 64'hA00);
    drv(32'h900, 3'b111, 0, 0, 0); chk("ar retry B00", 64'(maddr), 64'hB00);
    #1 reset = 1'b1;
    #1 chk("ar cmd cleared", 64'(cmd_o), 64'(0));
    chk("ar addr cleared", 64'(maddr), 64'(0));
    mtag = 4'd2;
    #1 chk("ar tag2 during reset", 64'(wr_en), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    drv(32'h900, 3'b111, 0, 2, 0); chk("ar tag2 after reset", 64'(wr_en), 64'(0));
    chk("ar cmd after reset", 64'(cmd_o), 64'(0));

    // ---- randomized against the reference model ----
    do_reset();
    for (int k = 0; k < 4; k++) begin
      m_busy[k] = 0; m_sent[k] = 0; m_blk[k] = '0; m_mt[k] = '0;
    end
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        addr[i]  = 32'h4000 + 32'($urandom_range(0, 5) << 3) + 32'($urandom_range(0, 1) << 2);
        cmdat[i] = {$urandom, $urandom};
      end
      cmv   = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      resp  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mdata = {$urandom, $urandom};
      flush = ($urandom_range(0, 19) == 0);
      mtag  = 4'd0;
      if ($urandom_range(0, 1) == 1) begin
        fr = $urandom_range(0, 3);
        if (m_busy[fr] && m_sent[fr]) mtag = m_mt[fr];
      end else if ($urandom_range(0, 4) == 0) begin
        mtag = 4'($urandom_range(0, 15));
      end
      #1;
      fk = -1; ik = -1; e_full = 1;
      for (int k = 0; k < 4; k++) begin
        if (fk < 0 && m_busy[k] && m_sent[k] && mtag != 0 && m_mt[k] == mtag) fk = k;
        if (ik < 0 && !flush && m_busy[k] && !m_sent[k]) ik = k;
        if (!m_busy[k]) e_full = 0;
      end
      chk($sformatf("r%0d cmd", c),   64'(cmd_o), 64'(ik >= 0 ? 1 : 0));
      chk($sformatf("r%0d maddr", c), 64'(maddr), ik >= 0 ? 64'({m_blk[ik], 3'b000}) : 64'(0));
      chk($sformatf("r%0d wr_en", c), 64'(wr_en), 64'(fk >= 0 ? 1 : 0));
      chk($sformatf("r%0d wr_data", c), wr_data, mdata);
      chk($sformatf("r%0d full", c),  64'(full),  64'(e_full));
      if (fk >= 0) begin
        chk($sformatf("r%0d wr_index", c), 64'(wr_index), 64'(m_blk[fk][4:0]));
        chk($sformatf("r%0d wr_tag", c),   64'(wr_tag),   64'(m_blk[fk][28:5]));
      end
      for (int i = 0; i < 3; i++) begin
        e_vld[i] = (fk >= 0 && addr[i][31:3] == m_blk[fk]) ? 1'b1 : cmv[i];
        src = (fk >= 0 && addr[i][31:3] == m_blk[fk]) ? mdata : cmdat[i];
        chk($sformatf("r%0d lane%0d data", c, i), 64'(dout[i]),
            64'(addr[i][2] ? src[63:32] : src[31:0]));
        chk($sformatf("r%0d lane%0d idx/tag", c, i), {32'(cur_tag[i]), 32'(cur_idx[i])},
            {32'(addr[i][31:8]), 32'(addr[i][7:3])});
      end
      chk($sformatf("r%0d valid", c), 64'(vout), 64'(e_vld));
      // Advance the model to the state after this cycle's edge.
      al = -1; fr = -1;
      for (int k = 0; k < 4; k++) if (fr < 0 && !m_busy[k]) fr = k;
      if (!e_full && !flush)
        for (int i = 0; i < 3; i++)
          if (al < 0 && !e_vld[i]) begin
            dup = 0;
            for (int k = 0; k < 4; k++) if (m_busy[k] && m_blk[k] == addr[i][31:3]) dup = 1;
            if (!dup) al = i;
          end
      if (flush) for (int k = 0; k < 4; k++) if (m_busy[k] && !m_sent[k]) m_busy[k] = 0;
      if (ik >= 0 && resp != 0) begin m_sent[ik] = 1; m_mt[ik] = resp; end
      if (fk >= 0) m_busy[fk] = 0;
      if (al >= 0) begin m_busy[fr] = 1; m_sent[fr] = 0; m_blk[fr] = addr[al][31:3]; end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/icache_mshr_ctrl.md
Name: icache_mshr_ctrl

Overview:
- Non-blocking instruction-cache miss controller. Successor to the single-miss icache controller.
- Serves FETCH_WIDTH parallel fetch lanes and tracks up to MSHR_DEPTH outstanding block misses.
- Issues one memory load per cycle, retries rejected requests, matches out-of-order memory tags, and bypasses returning fill data directly to fetch.
- Sits between fetch_stage, the icache data/tag array, and the memory bus.

Parameters:
- XLEN, 32, address width.
- FETCH_WIDTH, 3, number of fetch lanes; lane 0 is oldest in program order.
- IDX_BITS, 5, cache set index bits. Block = 8 bytes, so tag width TAG_BITS = XLEN-3-IDX_BITS (localparam).
- MSHR_DEPTH, 4, outstanding miss entries (>=1).
- MEM_TAG_BITS, 4, memory transaction tag width; tag 0 means "no transaction/rejected".

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  fetch redirect; discard unissued misses
- proc2Icache_addr  in  FETCH_WIDTH*XLEN  per-lane fetch PC
- cachemem_data  in  FETCH_WIDTH*64  per-lane array read block
- cachemem_valid  in  FETCH_WIDTH  per-lane array hit
- Imem2proc_response  in  MEM_TAG_BITS  tag accepted for this cycle's request (0 = rejected)
- Imem2proc_data  in  64  returning block data
- Imem2proc_tag  in  MEM_TAG_BITS  tag of returning data (0 = none)
- current_index  out  FETCH_WIDTH*IDX_BITS  per-lane array read index = addr[IDX_BITS+2:3]
- current_tag  out  FETCH_WIDTH*TAG_BITS  per-lane array read tag = addr[XLEN-1:IDX_BITS+3]
- proc2Imem_command  out  2  BUS_NONE or BUS_LOAD
- proc2Imem_addr  out  XLEN  {tag,index,3'b0} of issued entry
- wr_en  out  1  array fill write enable
- wr_index  out  IDX_BITS  fill index
- wr_tag  out  TAG_BITS  fill tag
- wr_data  out  64  fill data (= Imem2proc_data)
- Icache_data_out  out  FETCH_WIDTH*32  per-lane instruction word
- Icache_valid_out  out  FETCH_WIDTH  per-lane valid
- mshr_full  out  1  no FREE entry

Behaviour:
- Entry fields: state {FREE, PENDING, WAIT}, block tag, index, mem_tag. All state is registered.
- Reset: all entries FREE, mem_tags 0. Hence after reset: proc2Imem_command=BUS_NONE, proc2Imem_addr=0, mshr_full=0. wr_en=0 unless an input tag matches a WAIT entry, and no entry can be WAIT right after reset.
- Reset asserted mid-operation clears all entries immediately. In-flight memory responses arriving afterwards match nothing and are ignored.
- Word select: Icache_data_out[i] = addr[i][2] ? block[63:32] : block[31:0].
- Fill (combinational):
  - If Imem2proc_tag != 0 and equals mem_tag of a WAIT entry (lowest index on duplicates), then wr_en=1, wr_index/wr_tag come from that entry, and wr_data=Imem2proc_data.
  - That entry becomes FREE at the next edge.
- Bypass: any lane whose {tag,index} equals the filling entry's block gets Icache_valid_out=1, with data taken from Imem2proc_data that cycle. All other lanes get Icache_valid_out = cachemem_valid.
- Allocation (at most one per cycle, at the clock edge):
  - Candidate = lowest-numbered lane with valid_out=0 whose block matches no non-FREE entry and no other lane already chosen this cycle.
  - The candidate goes into the lowest-index FREE entry as PENDING.
  - No allocation when full (mshr_full=1) or when flush=1.
  - Miss seen at cycle t means the entry is PENDING at t+1 and is issued at t+1 at the earliest.
- Issue (combinational):
  - If any PENDING entry exists and flush=0: proc2Imem_command=BUS_LOAD and proc2Imem_addr=block of the lowest-index PENDING entry.
  - At the edge: if Imem2proc_response != 0, the entry becomes WAIT with mem_tag=response; if 0, it stays PENDING and is retried next cycle.
  - Otherwise BUS_NONE, addr 0.
- Flush: all PENDING entries become FREE at the edge. WAIT entries are kept and drain normally; their fills still write the array.
- Simultaneous events:
  - A fill freeing entry k and an allocation in the same cycle may not reuse k. k is counted FREE from the next cycle.
  - An issue and a fill to different entries in the same cycle are independent.
- Frees are out of order. There is no entry ordering beyond lowest-index priority.

Test Plan:
- Single miss: lane0 addr 0x100 misses, others hit; response 3 on the issue cycle; tag 3 returns 4 cycles later with data 0xDEADBEEF_12345678 → BUS_LOAD addr 0x100 for exactly one cycle; wr_en=1 with index 0, tag 1 (IDX_BITS=5); lane0 valid with data 0x12345678 that cycle.
- Dedupe: lanes 0,1,2 = 0x200, 0x204, 0x208 all miss → exactly two allocations over two cycles (0x200 and 0x208); 0x204 never gets an entry.
- Reject/retry: response 0 for 3 cycles, then 5 → BUS_LOAD 0x300 held for 4 cycles; entry goes WAIT with mem_tag 5.
- Full + out-of-order: 4 distinct misses with tags 1..4, then a 5th miss → mshr_full=1 and no 5th issue; return tag 3 first → its entry freed; 5th miss allocated the cycle after.
- Flush: 2 PENDING plus 1 WAIT entry, flush=1 for one cycle → BUS_NONE that cycle; PENDING entries freed; the WAIT fill still asserts wr_en when its tag returns.
- Async reset mid-flight: reset asserted between clock edges with a WAIT tag 2 outstanding → entries clear immediately; a later Imem2proc_tag=2 produces wr_en=0.
